// File: rtl/pe_sequencer_if.sv
// Configuration, upstream beat and PE-array beat signals of the PE sequencer.
// Every valid/ready pair transfers on a clock edge where both are high; a source that has
// raised valid keeps it and its payload stable until that edge.
interface pe_sequencer_if #(
    parameter int KW2_BITS = 3,
    parameter int CIN_BITS = 12,
    parameter int BLK_BITS = 10
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [KW2_BITS-1:0] cfg_kw2;
    logic [CIN_BITS-1:0] cfg_cin_m1;
    logic [BLK_BITS-1:0] cfg_blocks_m1;
    logic                s_valid;
    logic                s_ready;
    logic                m_valid;
    logic                m_ready;
    logic                m_last;
    logic                m_is_config;
    logic                m_is_cin_last;
    logic                m_is_w_first_clk;
    logic [KW2_BITS-1:0] m_kw2;
    logic [31:0]         perf_busy;
    logic [31:0]         perf_stall;

    // slave: the sequencer itself; master: the surrounding environment.
    modport slave (
        input  cfg_valid, cfg_kw2, cfg_cin_m1, cfg_blocks_m1, s_valid, m_ready,
        output cfg_ready, s_ready, m_valid, m_last, m_is_config, m_is_cin_last,
               m_is_w_first_clk, m_kw2, perf_busy, perf_stall
    );
    modport master (
        output cfg_valid, cfg_kw2, cfg_cin_m1, cfg_blocks_m1, s_valid, m_ready,
        input  cfg_ready, s_ready, m_valid, m_last, m_is_config, m_is_cin_last,
               m_is_w_first_clk, m_kw2, perf_busy, perf_stall
    );
endinterface

// File: rtl/pe_sequencer.sv
// Annotates a pass-through beat stream with tile/accumulation markers for the PE array.
// Define PE_SEQ_PERF_EN to build the saturating busy/stall performance counters.
module pe_sequencer #(
    parameter int KW2_BITS = 3,
    parameter int CIN_BITS = 12,
    parameter int BLK_BITS = 10
) (
    input  logic       clk,
    input  logic       reset,
    pe_sequencer_if.slave bus,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, CONFIG = 2'd1, RUN = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [KW2_BITS-1:0] kw2_q;
    logic [CIN_BITS-1:0] cin_m1_q, cin_cnt_q, cin_cnt_d;
    logic [BLK_BITS-1:0] blk_m1_q, blk_cnt_q, blk_cnt_d;
    logic                cfg_accept, active, run, mv, xfer, cin_last, blk_last;

    always_comb begin
        state_d    = state_q;
        cin_cnt_d  = cin_cnt_q;
        blk_cnt_d  = blk_cnt_q;
        cfg_accept = 1'b0;
        active     = (state_q != IDLE);
        run        = (state_q == RUN);
        mv         = active && bus.s_valid;
        xfer       = mv && bus.m_ready;
        cin_last   = (cin_cnt_q == cin_m1_q);
        blk_last   = (blk_cnt_q == blk_m1_q);

        bus.cfg_ready        = (state_q == IDLE);
        bus.m_valid          = mv;
        bus.s_ready          = active && bus.m_ready;
        bus.m_kw2            = kw2_q;
        bus.m_is_config      = mv && (state_q == CONFIG);
        bus.m_is_cin_last    = mv && run && cin_last;
        bus.m_is_w_first_clk = mv && run && (cin_cnt_q == '0) && (blk_cnt_q == '0);
        bus.m_last           = mv && run && cin_last && blk_last;

        case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    cfg_accept = 1'b1;
                    cin_cnt_d  = '0;
                    blk_cnt_d  = '0;
                    state_d    = CONFIG;
                end
            end
            CONFIG: begin
                if (xfer) state_d = RUN;
            end
            RUN: begin
                // Inner counter walks the accumulation; outer counter walks output blocks.
                if (xfer) begin
                    if (cin_last) begin
                        cin_cnt_d = '0;
                        if (blk_last) state_d = IDLE;
                        else          blk_cnt_d = blk_cnt_q + BLK_BITS'(1);
                    end else begin
                        cin_cnt_d = cin_cnt_q + CIN_BITS'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cin_cnt_q <= '0;
            blk_cnt_q <= '0;
            kw2_q     <= '0;
            cin_m1_q  <= '0;
            blk_m1_q  <= '0;
        end else begin
            state_q   <= state_d;
            cin_cnt_q <= cin_cnt_d;
            blk_cnt_q <= blk_cnt_d;
            if (cfg_accept) begin
                kw2_q    <= bus.cfg_kw2;
                cin_m1_q <= bus.cfg_cin_m1;
                blk_m1_q <= bus.cfg_blocks_m1;
            end
        end
    end

    assign state_dbg = state_q;

`ifdef PE_SEQ_PERF_EN
    logic [31:0] busy_q, stall_q;

    // Both counters hold at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            if (active && (busy_q != '1))
                busy_q <= busy_q + 32'd1;
            if (mv && !bus.m_ready && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.perf_busy  = busy_q;
    assign bus.perf_stall = stall_q;
`else
    assign bus.perf_busy  = '0;
    assign bus.perf_stall = '0;
`endif
endmodule

// File: tb/tb_pe_sequencer.sv
// Bench for pe_sequencer: table of tiles, hand-written corner sequences and random tiles,
// all scored against a beat-list model built from the tile shape.
module tb_pe_sequencer;
    localparam int KW2_BITS = 3;
    localparam int CIN_BITS = 12;
    localparam int BLK_BITS = 10;

    typedef struct {
        int kw2;
        int cin_m1;
        int blk_m1;
        int mode;           // 0: always ready, 1: m_ready toggles 1,0, 2: random
        int exp_run_beats;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state_dbg;

    pe_sequencer_if #(.KW2_BITS(KW2_BITS), .CIN_BITS(CIN_BITS), .BLK_BITS(BLK_BITS)) bus ();

    pe_sequencer #(.KW2_BITS(KW2_BITS), .CIN_BITS(CIN_BITS), .BLK_BITS(BLK_BITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Expected annotated beats: {is_config, is_cin_last, is_w_first_clk, last}
    logic [3:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         busy_exp = 0;
    int         stall_exp = 0;
    vec_t       vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build_tile(input int cin_m1, input int blk_m1);
        exp_q.delete();
        exp_q.push_back(4'b1000);
        for (int b = 0; b <= blk_m1; b++)
            for (int c = 0; c <= cin_m1; c++)
                exp_q.push_back({1'b0, c == cin_m1, (b == 0) && (c == 0),
                                 (c == cin_m1) && (b == blk_m1)});
    endtask

    task automatic check_perf();
`ifdef PE_SEQ_PERF_EN
        chk("perf_busy", bus.perf_busy, busy_exp);
        chk("perf_stall", bus.perf_stall, stall_exp);
`else
        chk("perf_busy_off", bus.perf_busy, 32'd0);
        chk("perf_stall_off", bus.perf_stall, 32'd0);
`endif
    endtask

    task automatic run_tile(input int kw2, input int cin_m1, input int blk_m1, input int mode,
                            output int run_beats);
        int         cyc;
        logic       held, sv, mr;
        logic [3:0] act;
        run_beats = 0;
        build_tile(cin_m1, blk_m1);
        bus.s_valid       = 1'b1;
        bus.m_ready       = 1'b1;
        bus.cfg_valid     = 1'b1;
        bus.cfg_kw2       = KW2_BITS'(kw2);
        bus.cfg_cin_m1    = CIN_BITS'(cin_m1);
        bus.cfg_blocks_m1 = BLK_BITS'(blk_m1);
        #1;
        chk("idle_cfg_ready", bus.cfg_ready, 1);
        chk("idle_m_valid", bus.m_valid, 0);
        chk("idle_s_ready", bus.s_ready, 0);
        step();
        bus.cfg_valid = 1'b0;
        cyc  = 0;
        held = 1'b0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            case (mode)
                0:       begin sv = 1'b1; mr = 1'b1; end
                1:       begin sv = 1'b1; mr = ((cyc % 2) == 0); end
                default: begin
                    sv = held ? 1'b1 : 1'($urandom_range(0, 1));
                    mr = 1'($urandom_range(0, 1));
                end
            endcase
            bus.s_valid = sv;
            bus.m_ready = mr;
            #1;
            busy_exp++;
            chk("busy_cfg_ready", bus.cfg_ready, 0);
            chk("m_valid_pass", bus.m_valid, sv);
            chk("s_ready_pass", bus.s_ready, mr);
            chk("m_kw2", bus.m_kw2, kw2);
            act = {bus.m_is_config, bus.m_is_cin_last, bus.m_is_w_first_clk, bus.m_last};
            if (sv) chk("beat_annot", act, exp_q[0]);
            else    chk("annot_quiet", act, 0);
            if (sv && mr) begin
                if (!exp_q[0][3]) run_beats++;
                void'(exp_q.pop_front());
            end
            if (sv && !mr) stall_exp++;
            held = sv && !mr;
            cyc++;
            step();
        end
        if (exp_q.size() != 0) chk("tile_timeout", exp_q.size(), 0);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        #1;
        chk("idle_after_tile", bus.cfg_ready, 1);
        check_perf();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, c, b;
        vecs[0] = '{kw2: 1, cin_m1: 2, blk_m1: 1, mode: 0, exp_run_beats: 6};
        vecs[1] = '{kw2: 1, cin_m1: 2, blk_m1: 1, mode: 1, exp_run_beats: 6};
        vecs[2] = '{kw2: 0, cin_m1: 0, blk_m1: 0, mode: 0, exp_run_beats: 1};
        vecs[3] = '{kw2: 3, cin_m1: 1, blk_m1: 2, mode: 1, exp_run_beats: 6};
        vecs[4] = '{kw2: 7, cin_m1: 0, blk_m1: 3, mode: 0, exp_run_beats: 4};
        vecs[5] = '{kw2: 2, cin_m1: 3, blk_m1: 0, mode: 1, exp_run_beats: 4};

        // clock/reset
        reset             = 1'b1;
        bus.cfg_valid     = 1'b0;
        bus.cfg_kw2       = '0;
        bus.cfg_cin_m1    = '0;
        bus.cfg_blocks_m1 = '0;
        bus.s_valid       = 1'b0;
        bus.m_ready       = 1'b0;
        #2;
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_m_kw2", bus.m_kw2, 0);
        chk("rst_annot", {bus.m_is_config, bus.m_is_cin_last, bus.m_is_w_first_clk, bus.m_last}, 0);
        check_perf();
        #21;
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_tile(vecs[i].kw2, vecs[i].cin_m1, vecs[i].blk_m1, vecs[i].mode, rb);
            chk("table_run_beats", rb, vecs[i].exp_run_beats);
        end

        // Mid-run reset after the second RUN beat of the basic tile
        bus.cfg_valid     = 1'b1;
        bus.cfg_kw2       = 3'd1;
        bus.cfg_cin_m1    = 12'd2;
        bus.cfg_blocks_m1 = 10'd1;
        bus.s_valid       = 1'b1;
        bus.m_ready       = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        step();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_cfg_ready", bus.cfg_ready, 1);
        chk("midrst_m_valid", bus.m_valid, 0);
        chk("midrst_m_last", bus.m_last, 0);
        chk("midrst_m_kw2", bus.m_kw2, 0);
        busy_exp  = 0;
        stall_exp = 0;
        check_perf();
        #2;
        reset = 1'b0;
        step();
        run_tile(1, 1, 0, 0, rb);
        chk("fresh_run_beats", rb, 2);

        // Configuration offered mid-tile is held off until IDLE
        bus.cfg_valid     = 1'b1;
        bus.cfg_kw2       = 3'd1;
        bus.cfg_cin_m1    = 12'd2;
        bus.cfg_blocks_m1 = 10'd1;
        bus.s_valid       = 1'b1;
        bus.m_ready       = 1'b1;
        step();
        bus.cfg_kw2       = 3'd2;
        bus.cfg_cin_m1    = 12'd0;
        bus.cfg_blocks_m1 = 10'd0;
        for (int i = 0; i < 7; i++) begin
            chk("midcfg_cfg_ready", bus.cfg_ready, 0);
            chk("midcfg_m_kw2", bus.m_kw2, 1);
            step();
        end
        chk("midcfg_idle_ready", bus.cfg_ready, 1);
        chk("midcfg_idle_kw2", bus.m_kw2, 1);
        step();
        bus.cfg_valid = 1'b0;
        chk("midcfg_new_kw2", bus.m_kw2, 2);
        chk("midcfg_busy", bus.cfg_ready, 0);
        step();
        step();
        chk("midcfg_done", bus.cfg_ready, 1);

        // Random tiles from a fresh reset so the perf model starts at zero
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        #2;
        reset = 1'b1;
        #2;
        reset     = 1'b0;
        busy_exp  = 0;
        stall_exp = 0;
        step();
        for (int t = 0; t < 25; t++) begin
            c = $urandom_range(0, 5);
            b = $urandom_range(0, 3);
            run_tile($urandom_range(0, 7), c, b, 2, rb);
            chk("rand_run_beats", rb, (c + 1) * (b + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
